// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, constants and GF(2^8) helpers.
package aes_pkg;

    localparam int NR    = 10;
    localparam int CNT_W = 4;

    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_state_e;

    // MSB position of byte (row, col); bytes are packed column-major from bit 127 down.
    function automatic int byte_hi(input int row, input int col);
        return 127 - 8 * (4 * col + row);
    endfunction

    // MSB position of 32-bit column col.
    function automatic int col_hi(input int col);
        return 127 - 32 * col;
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// InvMixColumns for one column: {0e,0b,0d,09} circulant over GF(2^8).
module aes_inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] result
);

    logic [7:0] a0, a1, a2, a3;

    // Row 0 sits in the top byte of the column.
    assign {a0, a1, a2, a3} = col;

    assign result = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
    };

endmodule

// File: rtl/aes_inv_sbox.sv
// Decryption S-box: undo the affine map, then take the GF(2^8) inverse.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] pre;

    assign pre      = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
                    ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
    assign out_byte = gf_inv(pre);

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption: one round per clock, round keys fetched by index.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and plaintext is held until taken.
module aes_decrypt_core #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    import aes_pkg::*;

    fsm_state_e       fsm_q, fsm_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    state_t isr;   // InvShiftRows(state)
    state_t isb;   // InvSubBytes(isr)
    state_t ark;   // isb XOR round key
    state_t imc;   // InvMixColumns(ark)

    // InvShiftRows is pure wiring; each byte then passes through an inverse S-box.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = byte_hi(r, c);
            localparam int SRC = byte_hi(r, (c + 4 - r) % 4);
            assign isr[DST -: 8] = state_q[SRC -: 8];
            aes_inv_sbox u_sbox (
                .in_byte  (isr[DST -: 8]),
                .out_byte (isb[DST -: 8])
            );
        end
        aes_inv_mix_column u_imc (
            .col    (ark[col_hi(c) -: 32]),
            .result (imc[col_hi(c) -: 32])
        );
    end

    assign ark = isb ^ rk;

    // FSM, data state and round counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and outputs; rk_idx depends only on registered fsm_q/cnt_q.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'd0;
        plaintext = '0;
        unique case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                rk_idx   = 4'(NR);
                if (in_valid) begin
                    state_d = ciphertext ^ rk;
                    cnt_d   = CNT_W'(NR - 1);
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                busy   = 1'b1;
                rk_idx = cnt_q;
                if (cnt_q == '0) begin
                    // Final round skips InvMixColumns.
                    state_d = ark;
                    fsm_d   = S_DONE;
                end else begin
                    state_d = imc;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                plaintext = state_q;
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed and randomized bench for aes_decrypt_core with a forward-AES reference model.
module tb_aes_decrypt_core;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] JUNK = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] rk;
    logic [127:0] plaintext;
    logic         in_ready, out_valid, busy;
    logic [3:0]   rk_idx;

    int n_vec = 0;
    int n_bad = 0;

    logic [127:0] rkeys [0:10];
    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_q [$];

    aes_decrypt_core #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // External key store: combinational round-key lookup.
    assign rk = (rk_idx <= 4'd10) ? rkeys[rk_idx] : '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (forward AES-128) ----------------
    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3)
                      ^ m_rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_keys(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                  ^ {rc, 24'h0};
                rc = m_xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rkeys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] m_encrypt(input logic [127:0] p);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        s = p ^ rkeys[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) s[127 - 8 * k -: 8] = sbox_t[s[127 - 8 * k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            s = t;
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32 * c -: 8];
                    a1 = s[119 - 32 * c -: 8];
                    a2 = s[111 - 32 * c -: 8];
                    a3 = s[103 - 32 * c -: 8];
                    s[127 - 32 * c -: 32] = {
                        m_xtime(a0) ^ m_xtime(a1) ^ a1 ^ a2 ^ a3,
                        a0 ^ m_xtime(a1) ^ m_xtime(a2) ^ a2 ^ a3,
                        a0 ^ a1 ^ m_xtime(a2) ^ m_xtime(a3) ^ a3,
                        m_xtime(a0) ^ a0 ^ a1 ^ a2 ^ m_xtime(a3)
                    };
                end
            end
            s = s ^ rkeys[rnd];
        end
        return s;
    endfunction

    // Called right after the accept edge; counts edges (accept edge = 1) until out_valid.
    // With poke set, in_valid and out_ready are pulsed mid-block and must be ignored.
    task automatic wait_done(input bit chk_rk, input bit poke, input string tag);
        int n;
        n = 1;
        while (!out_valid && n < 40) begin
            if (chk_rk && n <= 10) check({tag, "_rk_idx"}, 128'(rk_idx), 128'(10 - n));
            if (poke) begin
                in_valid   = (n == 3);
                ciphertext = JUNK;
                out_ready  = (n == 5);
            end
            tick();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_latency"}, 128'(n), 128'd11);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] p, c;
        int n, n_rx;
        bit done;

        build_sbox();
        load_keys(KEY1);

        // Reset state.
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_rk_idx", 128'(rk_idx), 128'd10);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_plaintext", plaintext, 128'd0);

        // Release reset with a block already offered: first edge must accept.
        rst_n      = 1'b1;
        in_valid   = 1'b1;
        ciphertext = CT1;
        tick();
        in_valid = 1'b0;
        check("first_edge_accept", 128'(busy), 128'd1);
        wait_done(1'b1, 1'b0, "v1");
        check("v1_out_valid", 128'(out_valid), 128'd1);
        check("v1_plaintext", plaintext, PT1);

        // Stall in DONE for 20 cycles, with a stray in_valid pulse.
        for (int i = 0; i < 20; i++) begin
            in_valid   = (i == 7);
            ciphertext = CT2;
            tick();
            check("stall_out_valid", 128'(out_valid), 128'd1);
            check("stall_plaintext", plaintext, PT1);
            check("stall_in_ready", 128'(in_ready), 128'd0);
            check("stall_busy", 128'(busy), 128'd1);
        end

        // Release: in_valid high on the DONE->IDLE edge must not be accepted.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("release_in_ready", 128'(in_ready), 128'd1);
        check("release_busy", 128'(busy), 128'd0);
        check("release_out_valid", 128'(out_valid), 128'd0);
        check("release_plaintext", plaintext, 128'd0);

        // Second vector, with in_valid and out_ready pulses during ROUND.
        load_keys(KEY2);
        check("v2_idle_rk_idx", 128'(rk_idx), 128'd10);
        in_valid   = 1'b1;
        ciphertext = CT2;
        tick();
        in_valid = 1'b0;
        wait_done(1'b1, 1'b1, "v2");
        check("v2_plaintext", plaintext, PT2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("v2_consumed", 128'(out_valid), 128'd0);
        check("v2_idle", 128'(in_ready), 128'd1);

        // Reset asserted around round 5 aborts the block.
        load_keys(KEY1);
        in_valid   = 1'b1;
        ciphertext = CT1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check("abort_at_round5", 128'(rk_idx), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_rk_idx", 128'(rk_idx), 128'd10);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_plaintext", plaintext, 128'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("post_abort_no_out", 128'(out_valid), 128'd0);
        end
        check("post_abort_busy", 128'(busy), 128'd0);

        // Rerun the first vector after the abort.
        in_valid   = 1'b1;
        ciphertext = CT1;
        tick();
        in_valid = 1'b0;
        wait_done(1'b1, 1'b0, "v1_rerun");
        check("v1_rerun_plaintext", plaintext, PT1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 100 random blocks with random output backpressure.
        load_keys({$urandom, $urandom, $urandom, $urandom});
        n_rx = 0;
        for (int i = 0; i < 100; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            c = m_encrypt(p);
            exp_q.push_back(p);
            repeat ($urandom_range(0, 2)) tick();
            in_valid   = 1'b1;
            ciphertext = c;
            n = 0;
            while (!in_ready && n < 50) begin
                tick();
                n++;
            end
            tick();
            in_valid = 1'b0;
            check("rnd_accept", 128'(busy), 128'd1);
            n    = 0;
            done = 1'b0;
            while (!done && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check("rnd_plaintext", plaintext, exp_q.pop_front());
                    n_rx++;
                    done = 1'b1;
                end
                tick();
                n++;
            end
            out_ready = 1'b0;
            check("rnd_handshake", 128'(done), 128'd1);
            check("rnd_no_dup", 128'(out_valid), 128'd0);
        end
        check("rnd_count", 128'(n_rx), 128'd100);
        check("rnd_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
